// File: rtl/tx_link_scheduler.sv
// Round-robin scheduler sharing one parity-checked serial sender, with NAK/timeout retry.
// Build option: define FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module tx_link_scheduler #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 4,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 64,
    localparam int OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_send,
    input  logic                    tx_busy,
    input  logic                    rx_ack,
    input  logic                    rx_nak,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        fail,
    output logic                    active,
    output logic [OW-1:0]           owner
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_TX, WAIT_RESP} state_t;

    state_t            state, state_n;
    logic [TW-1:0]     timer, timer_n;
    logic [RW-1:0]     retry_cnt, retry_n;
    logic [OW-1:0]     owner_n, grant_idx, cand;
    logic [DATA_W-1:0] tx_data_n;
    logic              tx_send_n, active_n, granted;
    logic [N_REQ-1:0]  done_n, fail_n, owner_oh;
    logic              attempt_ok, attempt_bad, expired;
`ifndef FIXED_PRIORITY_EN
    logic [OW-1:0]     rr_ptr, rr_n, rr_after;
`endif

    assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
    assign expired  = (timer == TW'(TIMEOUT - 1));
`ifndef FIXED_PRIORITY_EN
    assign rr_after = (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;
`endif

    // Descending scan so the last hit kept is the nearest candidate.
    always_comb begin
        grant_idx = '0;
        granted   = 1'b0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef FIXED_PRIORITY_EN
            cand = OW'(k);
`else
            cand = OW'((int'(rr_ptr) + k) % N_REQ);
`endif
            if (req[cand]) begin
                grant_idx = cand;
                granted   = 1'b1;
            end
        end
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        retry_n     = retry_cnt;
        owner_n     = owner;
        tx_data_n   = tx_data;
        tx_send_n   = 1'b0;
        done_n      = '0;
        fail_n      = '0;
        attempt_ok  = 1'b0;
        attempt_bad = 1'b0;
`ifndef FIXED_PRIORITY_EN
        rr_n        = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (granted) begin
                    owner_n   = grant_idx;
                    tx_data_n = req_data[int'(grant_idx)*DATA_W +: DATA_W];
                    retry_n   = '0;
                    state_n   = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_send_n = 1'b1;
                timer_n   = '0;
                state_n   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = WAIT_TX;
                    timer_n = '0;
                end else if (expired) attempt_bad = 1'b1;
                else timer_n = timer + 1'b1;
            end
            WAIT_TX: begin
                // A verdict may arrive before busy drops; NAK outranks ACK.
                if (rx_nak)        attempt_bad = 1'b1;
                else if (rx_ack)   attempt_ok  = 1'b1;
                else if (!tx_busy) begin
                    state_n = WAIT_RESP;
                    timer_n = '0;
                end else if (expired) attempt_bad = 1'b1;
                else timer_n = timer + 1'b1;
            end
            WAIT_RESP: begin
                if (rx_nak)       attempt_bad = 1'b1;
                else if (rx_ack)  attempt_ok  = 1'b1;
                else if (expired) attempt_bad = 1'b1;
                else timer_n = timer + 1'b1;
            end
            default: state_n = IDLE;
        endcase

        if (attempt_ok) begin
            done_n  = owner_oh;
            state_n = IDLE;
`ifndef FIXED_PRIORITY_EN
            rr_n    = rr_after;
`endif
        end
        if (attempt_bad) begin
            if (retry_cnt < RW'(MAX_RETRY)) begin
                retry_n = retry_cnt + 1'b1;
                state_n = LAUNCH;
            end else begin
                fail_n  = owner_oh;
                state_n = IDLE;
`ifndef FIXED_PRIORITY_EN
                rr_n    = rr_after;
`endif
            end
        end
        active_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            retry_cnt <= '0;
            owner     <= '0;
            tx_data   <= '0;
            tx_send   <= 1'b0;
            done      <= '0;
            fail      <= '0;
            active    <= 1'b0;
`ifndef FIXED_PRIORITY_EN
            rr_ptr    <= '0;
`endif
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            retry_cnt <= retry_n;
            owner     <= owner_n;
            tx_data   <= tx_data_n;
            tx_send   <= tx_send_n;
            done      <= done_n;
            fail      <= fail_n;
            active    <= active_n;
`ifndef FIXED_PRIORITY_EN
            rr_ptr    <= rr_n;
`endif
        end
    end

endmodule

// File: tb/tb_tx_link_scheduler.sv
// Bench for tx_link_scheduler: acts as sender/receiver and checks transfers against a transfer-level model.
module tb_tx_link_scheduler;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int MR = 3;
    localparam int TO = 64;

    localparam int V_ACK     = 0;
    localparam int V_NAK     = 1;
    localparam int V_BOTH    = 2;
    localparam int V_TO_BUSY = 3;
    localparam int V_TO_RESP = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   tx_data;
    logic            tx_send;
    logic            tx_busy, rx_ack, rx_nak;
    logic [N-1:0]    done, fail;
    logic            active;
    logic [1:0]      owner;

    int n_chk = 0, n_fail = 0;
    int send_cnt = 0, done_cnt = 0, fail_cnt = 0, excl_err = 0;
    int exp_done = 0, exp_fail = 0;
    int m_rr = 0;
    int last_owner = 0;
    bit spur;

    tx_link_scheduler #(.N_REQ(N), .DATA_W(DW), .MAX_RETRY(MR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
        .rx_ack(rx_ack), .rx_nak(rx_nak), .done(done), .fail(fail),
        .active(active), .owner(owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_send === 1'b1) send_cnt <= send_cnt + 1;
        done_cnt <= done_cnt + $countones(done);
        fail_cnt <= fail_cnt + $countones(fail);
        if (((|done) && (|fail)) || $countones(done) > 1 || $countones(fail) > 1)
            excl_err <= excl_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner: first requester at or above the pointer, wrapping to the lowest one.
    function automatic int pick(input logic [N-1:0] m);
        int lo;
        lo = -1;
        for (int i = N - 1; i >= 0; i--) if (m[i]) lo = i;
`ifndef FIXED_PRIORITY_EN
        for (int i = m_rr; i < N; i++) if (m[i]) return i;
`endif
        return lo;
    endfunction

    task automatic step();
        @(negedge clk);
        if (tx_send !== 1'b0 || done !== '0 || fail !== '0) spur = 1'b1;
    endtask

    // Entered on the cycle tx_send is seen; returns on the cycle the deciding event is presented.
    task automatic respond(input int vk, input int bcyc);
        int b, g;
        if (vk == V_TO_BUSY) begin
            repeat (TO - 1) step();
            return;
        end
        if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0) rx_ack = 1'b1; else rx_nak = 1'b1;
            step();
            rx_ack = 1'b0; rx_nak = 1'b0;
        end
        b = (bcyc > 0) ? bcyc : $urandom_range(1, 8);
        tx_busy = 1'b1;
        repeat (b) step();
        tx_busy = 1'b0;
        if (vk == V_TO_RESP) begin
            repeat (TO) step();
            return;
        end
        g = $urandom_range(0, 4);
        repeat (g) step();
        rx_ack = (vk == V_ACK || vk == V_BOTH);
        rx_nak = (vk == V_NAK || vk == V_BOTH);
    endtask

    task automatic do_xfer(input logic [N-1:0] rq, input int nfail, input int kind, input int bcyc);
        int own, s0, exp_sends, vk;
        logic [DW-1:0]   exp_data;
        logic [N-1:0]    oh;
        logic [N*DW-1:0] saved;
        own = pick(rq);
        oh = '0;
        oh[own] = 1'b1;
        exp_data  = req_data[own*DW +: DW];
        exp_sends = (nfail > MR) ? MR + 1 : nfail + 1;
        s0 = send_cnt;
        spur = 1'b0;
        saved = req_data;
        req = rq;
        @(negedge clk);
        chk("grant_active", active, 1);
        chk("grant_owner", owner, own);
        chk("grant_no_send", tx_send, 0);
        chk("grant_data", tx_data, exp_data);
        last_owner = own;
        req_data = (N*DW)'($urandom());
        @(negedge clk);
        chk("launch_send", tx_send, 1);
        chk("launch_data", tx_data, exp_data);
        for (int a = 0; a <= MR; a++) begin
            vk = (a < nfail) ? kind : V_ACK;
            respond(vk, bcyc);
            @(negedge clk);
            rx_ack = 1'b0; rx_nak = 1'b0; tx_busy = 1'b0;
            if (vk == V_ACK) begin
                chk("done_pulse", done, oh);
                chk("done_no_fail", fail, 0);
                chk("done_idle", active, 0);
                break;
            end else if (a == MR) begin
                chk("fail_pulse", fail, oh);
                chk("fail_no_done", done, 0);
                chk("fail_idle", active, 0);
            end else begin
                chk("retry_quiet", {done, fail}, 0);
                chk("retry_active", active, 1);
                @(negedge clk);
                chk("resend", tx_send, 1);
                chk("resend_data", tx_data, exp_data);
            end
        end
        chk("send_count", send_cnt - s0, exp_sends);
        chk("quiet_waits", spur, 0);
        if (nfail > MR) exp_fail++; else exp_done++;
`ifndef FIXED_PRIORITY_EN
        m_rr = (own + 1) % N;
`endif
        req = rq & ~oh;
        req_data = saved;
    endtask

    initial begin
        logic [N-1:0] m;
        int nf, kd;
        int rr_order[5] = '{0, 1, 2, 3, 0};

        rst_n = 1'b0; req = '0; req_data = '0;
        tx_busy = 1'b0; rx_ack = 1'b0; rx_nak = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_send", tx_send, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_active", active, 0);
        chk("rst_owner", owner, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin with all four requesting
        req_data = {4'h3, 4'h9, 4'hA, 4'hF};
        for (int i = 0; i < 5; i++) begin
            do_xfer(4'b1111, 0, V_ACK, 0);
`ifdef FIXED_PRIORITY_EN
            chk("rr_order", last_owner, 0);
`else
            chk("rr_order", last_owner, rr_order[i]);
`endif
        end

        // Single request with a 6-cycle busy window, then pointer moves past 0
        req_data = 16'h0005;
        do_xfer(4'b0001, 0, V_ACK, 6);
        chk("single_data_owner", last_owner, 0);
        req_data = 16'h00C7;
        do_xfer(4'b0011, 0, V_ACK, 0);
`ifdef FIXED_PRIORITY_EN
        chk("rr_ptr_after_single", last_owner, 0);
`else
        chk("rr_ptr_after_single", last_owner, 1);
`endif

        // Parity retry, exhaustion, timeouts, simultaneous ack+nak
        req_data = 16'h00D0;
        do_xfer(4'b0010, 2, V_NAK, 0);
        do_xfer(4'b0100, 9, V_NAK, 0);
        do_xfer(4'b1000, 9, V_TO_BUSY, 0);
        do_xfer(4'b0001, 1, V_BOTH, 0);
        do_xfer(4'b0010, 1, V_TO_RESP, 0);

        // Reset while the sender is busy
        req_data = 16'h4321;
        req = 4'b0100;
        @(negedge clk);
        chk("rst6_grant", owner, 2);
        @(negedge clk);
        chk("rst6_send", tx_send, 1);
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; tx_busy = 1'b0; req = 4'b0101;
        chk("rst6_outputs", {tx_send, tx_data, done, fail, active, owner}, 0);
        m_rr = 0;
        do_xfer(4'b0101, 0, V_ACK, 0);
        chk("rst6_fresh_owner", last_owner, 0);

        for (int t = 0; t < 20; t++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            req_data = (N*DW)'($urandom());
            nf = $urandom_range(0, 5);
            kd = $urandom_range(1, 4);
            if (kd >= V_TO_BUSY && $urandom_range(0, 2) != 0) kd = V_NAK;
            do_xfer(m, nf, kd, 0);
        end

        repeat (3) @(negedge clk);
        chk("done_total", done_cnt, exp_done);
        chk("fail_total", fail_cnt, exp_fail);
        chk("done_fail_exclusive", excl_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_link_scheduler.md
Name: tx_link_scheduler

Overview:
Round-robin scheduler that shares one parity-protected serial sender among N_REQ requesters. It latches the granted requester's nibble, pulses the sender's start strobe, and tracks sender busy. It then waits for the receiver's parity verdict, retransmitting on NAK or timeout up to MAX_RETRY times. It sits between requester logic and the sender/receiver pair and reports per-requester done/fail.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 4, payload width per transfer (matches sender input)
MAX_RETRY, 3, retransmissions allowed after the first attempt
TIMEOUT, 64, cycles allowed in each wait state before the attempt counts as failed

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous, active-low reset
req  in  N_REQ  level request per requester; held until its done/fail
req_data  in  N_REQ*DATA_W  payload; slot i at [i*DATA_W +: DATA_W]
tx_data  out  DATA_W  to sender data input
tx_send  out  1  one-cycle start strobe to sender
tx_busy  in  1  sender busy
rx_ack  in  1  receiver pulse: frame received, parity good
rx_nak  in  1  receiver pulse: frame received, parity bad
done  out  N_REQ  one-cycle pulse on owner bit: transfer acknowledged
fail  out  N_REQ  one-cycle pulse on owner bit: retries exhausted
active  out  1  high whenever state != IDLE
owner  out  clog2(N_REQ)  index of current grant; valid while active

Behaviour:
- All outputs are registered. Reset values: tx_data=0, tx_send=0, done=0, fail=0, active=0, owner=0. Also on reset: rr_ptr=0, retry_cnt=0, timer=0, state=IDLE.
- States:
  - IDLE: if any req is set, pick the winner by round-robin starting at rr_ptr; latch owner and the slot data into tx_data; retry_cnt=0; go to LAUNCH.
  - LAUNCH: tx_send=1 for exactly this cycle; timer=0; go to WAIT_BUSY.
  - WAIT_BUSY: on tx_busy=1 go to WAIT_TX with timer=0.
  - WAIT_TX: on tx_busy=0 go to WAIT_RESP with timer=0.
  - WAIT_RESP: wait for a verdict.
- Latency: req asserted in IDLE at cycle 0 gives tx_send=1 at cycle 2 (grant registered at cycle 1, strobe at cycle 2). done or fail pulses the cycle after the deciding event is sampled.
- Verdicts: rx_ack/rx_nak are sampled only in WAIT_TX and WAIT_RESP and ignored in every other state.
  - ack: pulse done[owner], set rr_ptr=(owner+1) mod N_REQ, go to IDLE.
  - nak: treated as a failed attempt.
  - ack and nak in the same cycle: nak wins.
- Timeout: in WAIT_BUSY, WAIT_TX and WAIT_RESP the timer counts up. timer==TIMEOUT-1 without the exit event counts as a failed attempt.
- Failed attempt:
  - If retry_cnt<MAX_RETRY: retry_cnt+=1, go to LAUNCH, resend the same latched tx_data.
  - Otherwise: pulse fail[owner], set rr_ptr=(owner+1) mod N_REQ, go to IDLE.
- tx_data holds stable from grant until return to IDLE. req_data changes after grant are not seen.
- If a requester drops req mid-transfer, the transfer still completes and done/fail still pulses.
- A new grant is evaluated only in IDLE, so there is at least one idle cycle between transfers.
- done and fail are never asserted together, and at most one bit is set.
- rst_n=0 mid-transfer: next edge returns to IDLE with reset values. No done/fail pulse is issued for the aborted transfer.

Optional Feature:
Macro FIXED_PRIORITY_EN.
- Defined: the lowest-index active req always wins; rr_ptr is neither used nor updated.
- Undefined: round-robin as described above.
- Retry, timeout and handshake behaviour are identical in both builds.

Test Plan:
1. Single request: req=0001, slot0=5; sender busy 6 cycles, then rx_ack. Expect tx_send once with tx_data=5, done=0001 pulse, active back to 0, rr_ptr=1.
2. Round-robin: req=1111 held, slots=F,A,9,3, every frame acked. Expect grant order 0,1,2,3,0. Under FIXED_PRIORITY_EN, requester 0 repeats.
3. Parity retry: req=0010, slot1=D; rx_nak on the first two attempts, ack on the third. Expect three tx_send pulses, all with tx_data=D, then done=0010 and no fail.
4. Exhaustion: req=0100, rx_nak on every attempt, MAX_RETRY=3. Expect four tx_send pulses, then fail=0100 and no done.
5. Timeout: tx_busy never asserts. Expect relaunch every TIMEOUT+1 cycles, then fail after the fourth attempt. Also: rx_ack and rx_nak in the same cycle count as NAK.
6. Reset mid-transfer: drop rst_n for one cycle during WAIT_TX. Expect all outputs 0 next cycle, no done/fail pulse, and a fresh arbitration from requester 0.
